// File: rtl/memory_writeback_cycle.sv
// Combined MEM/WB stage: runs one req/ack data-memory transaction per load or store,
// stalls the upstream pipeline while it is outstanding, and registers the write-back triple.
module memory_writeback_cycle #(
  parameter int DATA_W  = 18,
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWriteM,
  input  logic              MemWriteM,
  input  logic              ResultSrcM,
  input  logic [4:0]        RDM,
  input  logic [DATA_W-1:0] ALUResultM,
  input  logic [DATA_W-1:0] WriteDataM,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              StallM,
  output logic              RegWriteW,
  output logic [4:0]        RDW,
  output logic [DATA_W-1:0] ResultW,
  output logic              MemErr
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic {IDLE, REQ} state_t;

  state_t            state_reg, state_next;
  logic [CW-1:0]     cnt_reg, cnt_next;
  logic              req_reg, req_next;
  logic              we_reg, we_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
  logic              load_reg, load_next;
  logic [4:0]        rd_reg, rd_next;
  logic              rw_reg, rw_next;
  logic              rw_w_reg, rw_w_next;
  logic [4:0]        rd_w_reg, rd_w_next;
  logic [DATA_W-1:0] result_w_reg, result_w_next;
  logic              err_reg, err_next;
  logic              access;
  logic              timeout_hit;
  logic              stall;

  assign access      = ResultSrcM | MemWriteM;
  // An ack in the final allowed cycle takes priority over the timeout.
  assign timeout_hit = (state_reg == REQ) && (cnt_reg == CNT_LAST) && !mem_ack;

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    req_next      = req_reg;
    we_next       = we_reg;
    addr_next     = addr_reg;
    wdata_next    = wdata_reg;
    load_next     = load_reg;
    rd_next       = rd_reg;
    rw_next       = rw_reg;
    rw_w_next     = rw_w_reg;
    rd_w_next     = rd_w_reg;
    result_w_next = result_w_reg;
    err_next      = 1'b0;
    stall         = 1'b0;

    case (state_reg)
      IDLE: begin
        if (access) begin
          stall      = 1'b1;
          we_next    = MemWriteM;
          addr_next  = ALUResultM[ADDR_W-1:0];
          wdata_next = WriteDataM;
          load_next  = ResultSrcM;
          rd_next    = RDM;
          rw_next    = RegWriteM;
          rw_w_next  = 1'b0;
          cnt_next   = '0;
          req_next   = 1'b1;
          state_next = REQ;
        end else begin
          rw_w_next     = RegWriteM;
          rd_w_next     = RDM;
          result_w_next = ALUResultM;
        end
      end
      REQ: begin
        stall = !mem_ack && !timeout_hit;
        if (mem_ack || timeout_hit) begin
          state_next = IDLE;
          req_next   = 1'b0;
          err_next   = timeout_hit;
          if (load_reg) begin
            rw_w_next     = rw_reg;
            rd_w_next     = rd_reg;
            result_w_next = mem_ack ? mem_rdata : '0;
          end else begin
            rw_w_next = 1'b0;
          end
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      default: begin
        state_next = IDLE;
        req_next   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      req_reg      <= 1'b0;
      we_reg       <= 1'b0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      load_reg     <= 1'b0;
      rd_reg       <= '0;
      rw_reg       <= 1'b0;
      rw_w_reg     <= 1'b0;
      rd_w_reg     <= '0;
      result_w_reg <= '0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      req_reg      <= req_next;
      we_reg       <= we_next;
      addr_reg     <= addr_next;
      wdata_reg    <= wdata_next;
      load_reg     <= load_next;
      rd_reg       <= rd_next;
      rw_reg       <= rw_next;
      rw_w_reg     <= rw_w_next;
      rd_w_reg     <= rd_w_next;
      result_w_reg <= result_w_next;
      err_reg      <= err_next;
    end
  end

  assign mem_req   = req_reg;
  assign mem_we    = we_reg;
  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata_reg;
  assign StallM    = stall;
  assign RegWriteW = rw_w_reg;
  assign RDW       = rd_w_reg;
  assign ResultW   = result_w_reg;
  assign MemErr    = err_reg;

endmodule

// File: tb/tb_memory_writeback_cycle.sv
// Directed bench for memory_writeback_cycle with TIMEOUT=4; expected values are hand-computed.
module tb_memory_writeback_cycle;

  localparam int DATA_W  = 18;
  localparam int ADDR_W  = 10;
  localparam int TIMEOUT = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              RegWriteM, MemWriteM, ResultSrcM;
  logic [4:0]        RDM;
  logic [DATA_W-1:0] ALUResultM, WriteDataM;
  logic              mem_req, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              StallM, RegWriteW;
  logic [4:0]        RDW;
  logic [DATA_W-1:0] ResultW;
  logic              MemErr;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  memory_writeback_cycle #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .RDM(RDM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .StallM(StallM), .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW),
    .MemErr(MemErr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic set_m(input logic rw, input logic mw, input logic rs, input logic [4:0] rd,
                       input logic [DATA_W-1:0] alu, input logic [DATA_W-1:0] wd);
    RegWriteM = rw; MemWriteM = mw; ResultSrcM = rs;
    RDM = rd; ALUResultM = alu; WriteDataM = wd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    set_m(1'b0, 1'b0, 1'b0, 5'd0, '0, '0);

    // Reset with a load pending in M
    set_m(1'b1, 1'b0, 1'b1, 5'd3, 18'h00055, 18'h0);
    step(); step();
    check("rst_mem_req",  mem_req,   0);
    check("rst_mem_we",   mem_we,    0);
    check("rst_mem_addr", mem_addr,  0);
    check("rst_wdata",    mem_wdata, 0);
    check("rst_regwrW",   RegWriteW, 0);
    check("rst_rdW",      RDW,       0);
    check("rst_resultW",  ResultW,   0);
    check("rst_memerr",   MemErr,    0);
    rst = 1'b1;
    #1;
    check("rel_stall", StallM, 1);
    step();
    check("rel_req",  mem_req,  1);
    check("rel_addr", mem_addr, 10'h055);
    mem_ack = 1'b1; mem_rdata = 18'h00123;
    #1;
    check("rel_ack_stall", StallM, 0);
    step();
    mem_ack = 1'b0;
    set_m(1'b0, 1'b0, 1'b0, 5'd0, '0, '0);
    check("rel_regwrW", RegWriteW, 1);
    check("rel_rdW",    RDW,       3);
    check("rel_result", ResultW,   18'h00123);
    check("rel_req_lo", mem_req,   0);

    // ALU pass-through
    set_m(1'b1, 1'b0, 1'b0, 5'd5, 18'h0002A, 18'h0);
    #1;
    check("alu_stall", StallM, 0);
    step();
    check("alu_regwrW", RegWriteW, 1);
    check("alu_rdW",    RDW,       5);
    check("alu_result", ResultW,   18'h0002A);
    check("alu_req",    mem_req,   0);

    // Load with ack three cycles after M (t+3)
    set_m(1'b1, 1'b0, 1'b1, 5'd7, 18'h30010, 18'h0);
    #1;
    check("ld_stall_t", StallM, 1);
    step();
    check("ld_req_t1",   mem_req,   1);
    check("ld_we",       mem_we,    0);
    check("ld_addr",     mem_addr,  10'h010);
    check("ld_stall_t1", StallM,    1);
    check("ld_bubble",   RegWriteW, 0);
    step();
    check("ld_req_t2",   mem_req, 1);
    check("ld_stall_t2", StallM,  1);
    step();
    mem_ack = 1'b1; mem_rdata = 18'h1ABCD;
    #1;
    check("ld_stall_t3", StallM, 0);
    step();
    mem_ack = 1'b0; mem_rdata = '0;
    set_m(1'b0, 1'b0, 1'b0, 5'd0, '0, '0);
    check("ld_regwrW", RegWriteW, 1);
    check("ld_rdW",    RDW,       7);
    check("ld_result", ResultW,   18'h1ABCD);
    check("ld_req_t4", mem_req,   0);

    // Store with zero-wait ack; RegWriteM set to confirm a store never writes back
    set_m(1'b1, 1'b1, 1'b0, 5'd4, 18'h00044, 18'h00155);
    #1;
    check("st_stall_t", StallM, 1);
    step();
    check("st_req",   mem_req,   1);
    check("st_we",    mem_we,    1);
    check("st_wdata", mem_wdata, 18'h00155);
    check("st_addr",  mem_addr,  10'h044);
    mem_ack = 1'b1;
    #1;
    check("st_stall_t1", StallM, 0);
    step();
    mem_ack = 1'b0;
    set_m(1'b0, 1'b0, 1'b0, 5'd0, 18'h00001, '0);
    check("st_regwrW", RegWriteW, 0);
    check("st_req_lo", mem_req,   0);
    check("st_result_held", ResultW, 18'h1ABCD);

    // Load timeout: no ack for TIMEOUT cycles
    set_m(1'b1, 1'b0, 1'b1, 5'd9, 18'h00123, 18'h0);
    mem_rdata = 18'h3FFFF;
    #1;
    check("to_stall_t", StallM, 1);
    for (int k = 1; k <= TIMEOUT; k++) begin
      step();
      check($sformatf("to_req_%0d", k),    mem_req, 1);
      check($sformatf("to_stall_%0d", k),  StallM,  (k < TIMEOUT) ? 1 : 0);
      check($sformatf("to_memerr_%0d", k), MemErr,  0);
    end
    step();
    set_m(1'b0, 1'b0, 1'b0, 5'd0, '0, '0);
    check("to_memerr",  MemErr,    1);
    check("to_req_lo",  mem_req,   0);
    check("to_regwrW",  RegWriteW, 1);
    check("to_rdW",     RDW,       9);
    check("to_result0", ResultW,   0);
    step();
    check("to_memerr_pulse", MemErr, 0);

    // Ack in the final allowed REQ cycle beats the timeout
    set_m(1'b1, 1'b0, 1'b1, 5'd10, 18'h00200, 18'h0);
    mem_rdata = '0;
    step(); step(); step();
    check("ackl_stall_3", StallM, 1);
    step();
    mem_ack = 1'b1; mem_rdata = 18'h0BEEF;
    #1;
    check("ackl_stall_4", StallM, 0);
    step();
    mem_ack = 1'b0; mem_rdata = '0;
    set_m(1'b0, 1'b0, 1'b0, 5'd0, '0, '0);
    check("ackl_memerr", MemErr,    0);
    check("ackl_regwrW", RegWriteW, 1);
    check("ackl_rdW",    RDW,       10);
    check("ackl_result", ResultW,   18'h0BEEF);
    check("ackl_req_lo", mem_req,   0);

    // Stray ack in IDLE, then back-to-back load and store
    mem_ack = 1'b1; mem_rdata = 18'h11111;
    step();
    mem_ack = 1'b0;
    check("stray_req",    mem_req, 0);
    check("stray_memerr", MemErr,  0);
    check("stray_result", ResultW, 0);
    set_m(1'b1, 1'b0, 1'b1, 5'd12, 18'h000AA, 18'h0);
    step();
    check("bb_ld_req",  mem_req,  1);
    check("bb_ld_addr", mem_addr, 10'h0AA);
    mem_ack = 1'b1; mem_rdata = 18'h2468A;
    step();
    mem_ack = 1'b0; mem_rdata = '0;
    set_m(1'b0, 1'b1, 1'b0, 5'd0, 18'h000BB, 18'h03C3C);
    #1;
    check("bb_gap_req",  mem_req,   0);
    check("bb_st_stall", StallM,    1);
    check("bb_ld_rw",    RegWriteW, 1);
    check("bb_ld_rd",    RDW,       12);
    check("bb_ld_res",   ResultW,   18'h2468A);
    step();
    check("bb_st_req",   mem_req,   1);
    check("bb_st_we",    mem_we,    1);
    check("bb_st_addr",  mem_addr,  10'h0BB);
    check("bb_st_wdata", mem_wdata, 18'h03C3C);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    set_m(1'b0, 1'b0, 1'b0, 5'd0, '0, '0);
    check("bb_st_rw",   RegWriteW, 0);
    check("bb_end_req", mem_req,   0);
    step();
    check("bb_no_retx", mem_req, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
